// File: rtl/pic_request_resolver_if.sv
// Request/acknowledge bundle between the CPU side and the PIC resolver.
// intr is the interrupt line to the CPU (int is a reserved word).
interface pic_request_resolver_if;
  logic [7:0] ir;
  logic [7:0] imr;
  logic       ltim;
  logic       inta;
  logic       eoi;
  logic       intr;
  logic [7:0] int_no;
  logic [7:0] vector;
  logic       vector_valid;

  modport master (
    output ir, imr, ltim, inta, eoi,
    input  intr, int_no, vector, vector_valid
  );

  modport slave (
    input  ir, imr, ltim, inta, eoi,
    output intr, int_no, vector, vector_valid
  );
endinterface

// File: rtl/pic_request_resolver.sv
// IRR latch, mask, priority pick and two-pulse INTA handshake.
// Optional rotating priority: define PIC_ROTATE_PRIORITY_EN.
module pic_request_resolver #(
  parameter logic [4:0] VECTOR_BASE = 5'b00100
) (
  input logic clk,
  input logic rst_n,
  pic_request_resolver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK1,
    SVC
  } state_t;

  state_t     state;
  logic [7:0] irr;
  logic [7:0] ir_q;
  logic [7:0] int_no_q;
  logic [7:0] vector_q;
  logic       vector_valid_q;
  logic [2:0] id_q;
  logic       spur_q;

  logic [7:0] pending;
  logic [2:0] start;
  logic [2:0] idx;
  logic       grant_hit;
  logic [2:0] grant_id;
  logic [7:0] grant_oh;
  logic [7:0] clr;
  logic [7:0] irr_next;

`ifdef PIC_ROTATE_PRIORITY_EN
  logic [2:0] ptr;
  assign start = ptr + 3'd1;
`else
  assign start = 3'd0;
`endif

  assign pending  = irr & ~bus.imr;
  assign grant_oh = 8'b1 << grant_id;

  // Circular search for the first pending line from start.
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = 3'd7;
    idx       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!grant_hit && pending[idx]) begin
        grant_hit = 1'b1;
        grant_id  = idx;
      end
    end
  end

  // Next IRR: live line in level mode, edge capture with set-wins.
  always_comb begin
    clr = 8'h00;
    if (state == REQ && bus.inta && grant_hit)
      clr = grant_oh;
    if (bus.ltim)
      irr_next = bus.ir;
    else
      irr_next = (irr & ~clr) | (bus.ir & ~ir_q);
  end

  // Handshake FSM with registered grant, vector and qualifier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      irr            <= 8'h00;
      ir_q           <= 8'h00;
      int_no_q       <= 8'h00;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      id_q           <= 3'd0;
      spur_q         <= 1'b0;
`ifdef PIC_ROTATE_PRIORITY_EN
      ptr            <= 3'd7;
`endif
    end else begin
      ir_q           <= bus.ir;
      irr            <= irr_next;
      vector_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|pending)
            state <= REQ;
        end
        REQ: begin
          if (bus.inta) begin
            if (grant_hit) begin
              int_no_q <= grant_oh;
              id_q     <= grant_id;
              spur_q   <= 1'b0;
            end else begin
              int_no_q <= 8'h00;
              id_q     <= 3'd7;
              spur_q   <= 1'b1;
            end
            state <= ACK1;
          end
        end
        ACK1: begin
          if (bus.inta) begin
            vector_q       <= {VECTOR_BASE, id_q};
            vector_valid_q <= 1'b1;
            state          <= spur_q ? IDLE : SVC;
          end
        end
        SVC: begin
          if (bus.eoi) begin
            int_no_q <= 8'h00;
`ifdef PIC_ROTATE_PRIORITY_EN
            ptr      <= id_q;
`endif
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.intr         = (state == REQ);
  assign bus.int_no       = int_no_q;
  assign bus.vector       = vector_q;
  assign bus.vector_valid = vector_valid_q;

endmodule

// File: tb/tb_pic_request_resolver.sv
// Directed plus random bench for pic_request_resolver.
// Reference model is a transaction-level view of the handshake.
module tb_pic_request_resolver;

  localparam logic [4:0] VB = 5'b00100;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  pic_request_resolver_if bus();

  pic_request_resolver #(.VECTOR_BASE(VB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // model state: phase 0 idle, 1 requesting, 2 first ack seen, 3 in service
  bit [7:0] m_irr, m_irq, m_int_no, m_vec;
  bit       m_vv, m_spur;
  int       m_phase, m_id, m_ptr;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input bit [7:0] p, input int first);
    for (int k = 0; k < 8; k++)
      if (p[(first + k) % 8]) return (first + k) % 8;
    return -1;
  endfunction

  task automatic model_step();
    bit [7:0] pend, clr;
    int g;
    clr  = 8'h00;
    m_vv = 1'b0;
    if (!rst_n) begin
      m_irr = 0; m_irq = 0; m_int_no = 0; m_vec = 0;
      m_phase = 0; m_id = 0; m_spur = 0; m_ptr = 7;
      return;
    end
    pend = m_irr & ~bus.imr;
    if (m_phase == 0) begin
      if (pend != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (bus.inta) begin
`ifdef PIC_ROTATE_PRIORITY_EN
        g = pick(pend, (m_ptr + 1) % 8);
`else
        g = pick(pend, 0);
`endif
        if (g < 0) begin
          m_int_no = 0; m_id = 7; m_spur = 1;
        end else begin
          m_int_no = 8'(1 << g); m_id = g; m_spur = 0;
          clr = 8'(1 << g);
        end
        m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (bus.inta) begin
        m_vec = {VB, 3'(m_id)};
        m_vv  = 1'b1;
        m_phase = m_spur ? 0 : 3;
      end
    end else begin
      if (bus.eoi) begin
        m_int_no = 0;
        m_ptr = m_id;
        m_phase = 0;
      end
    end
    if (bus.ltim) m_irr = bus.ir;
    else m_irr = (m_irr & ~clr) | (bus.ir & ~m_irq);
    m_irq = bus.ir;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("int", bus.intr, (m_phase == 1));
    chk("int_no", bus.int_no, m_int_no);
    chk("vector", bus.vector, m_vec);
    chk("vector_valid", bus.vector_valid, m_vv);
  endtask

  task automatic serve(input logic [7:0] exp_no, input logic [7:0] exp_vec);
    int n = 0;
    while (!bus.intr && n < 20) begin tick(); n++; end
    chk("serve_int", bus.intr, 8'h01);
    bus.inta = 1; tick(); bus.inta = 0;
    chk("grant", bus.int_no, exp_no);
    bus.inta = 1; tick(); bus.inta = 0;
    chk("serve_vec", bus.vector, exp_vec);
    chk("serve_vv", bus.vector_valid, 8'h01);
    bus.eoi = 1; tick(); bus.eoi = 0;
    chk("eoi_clr", bus.int_no, 8'h00);
  endtask

  initial begin
    bus.ir = 0; bus.imr = 0; bus.ltim = 0; bus.inta = 0; bus.eoi = 0;
    rst_n = 0;
    tick(); tick();
    chk("rst_int", bus.intr, 8'h00);
    chk("rst_int_no", bus.int_no, 8'h00);
    rst_n = 1;

    // edge mode, two requests in one pulse
    bus.ir = 8'h24; tick();
    chk("t1_int_k", bus.intr, 8'h00);
    bus.ir = 8'h00; tick();
    chk("t1_int_k1", bus.intr, 8'h01);
    serve(8'h04, 8'h22);
    serve(8'h20, 8'h25);

    // masked IR0, unmask during service
    bus.imr = 8'h01; bus.ir = 8'h03; tick();
    bus.ir = 8'h00; tick();
    bus.inta = 1; tick(); bus.inta = 0;
    chk("t2_grant", bus.int_no, 8'h02);
    bus.inta = 1; tick(); bus.inta = 0;
    bus.imr = 8'h00; tick(); tick();
    chk("t2_hold", bus.int_no, 8'h02);
    bus.eoi = 1; tick(); bus.eoi = 0;
    chk("t2_eoi", bus.int_no, 8'h00);
    serve(8'h01, 8'h20);

    // level mode spurious
    bus.ltim = 1; bus.ir = 8'h08; tick(); tick();
    chk("t3_int", bus.intr, 8'h01);
    bus.ir = 8'h00; tick();
    bus.inta = 1; tick(); bus.inta = 0;
    chk("t3_no", bus.int_no, 8'h00);
    bus.inta = 1; tick(); bus.inta = 0;
    chk("t3_vec", bus.vector, 8'h27);
    chk("t3_vv", bus.vector_valid, 8'h01);
    tick(); tick();
    chk("t3_idle", bus.intr, 8'h00);
    bus.ltim = 0;

    // reset while in service with a pending line
    bus.ir = 8'h10; tick();
    bus.ir = 8'h00; tick();
    bus.inta = 1; tick(); tick(); bus.inta = 0;
    chk("t4_svc", bus.int_no, 8'h10);
    bus.ir = 8'h01; tick();
    rst_n = 0; tick();
    chk("t4_rst_no", bus.int_no, 8'h00);
    chk("t4_rst_vec", bus.vector, 8'h00);
    rst_n = 1; bus.ir = 8'h00; tick(); tick(); tick();
    chk("t4_irr_empty", bus.intr, 8'h00);

    // rotation (or fixed) with held level requests
    bus.ltim = 1; bus.ir = 8'h09;
`ifdef PIC_ROTATE_PRIORITY_EN
    serve(8'h01, 8'h20); serve(8'h08, 8'h23);
    serve(8'h01, 8'h20); serve(8'h08, 8'h23);
`else
    for (int i = 0; i < 4; i++) serve(8'h01, 8'h20);
`endif
    bus.ir = 8'h00; tick(); bus.ltim = 0; tick();
    rst_n = 0; tick(); rst_n = 1;

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) bus.ltim = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        bus.ir = bus.ir ^ (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) bus.imr = 8'($urandom) & 8'($urandom);
      bus.inta = ($urandom_range(0, 2) == 0);
      bus.eoi  = ($urandom_range(0, 3) == 0);
      rst_n    = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
